imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory interface: receives a byte stream over a valid/ready handshake and assembles 32-bit instruction words.
- Issues one-cycle word writes (WE/A/WD) so a program can be preloaded into instruction memory before the single-cycle MIPS core runs.
- Sits between a byte source (UART receiver or testbench driver) and the instruction memory write port.

Parameters:
- BASE_ADDR, 32'h00000000: byte address of the first word written.
- MAX_WORDS, 64: instruction memory depth in words; the load stops after this many writes.
- CW, 7: width of word_count; must satisfy 2**CW > MAX_WORDS.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  incoming program byte
- byte_ready  out  1  loader accepts a byte this cycle
- WE  out  1  instruction memory write enable, one-cycle pulse
- A  out  32  write byte address, word aligned
- WD  out  32  write data
- busy  out  1  high in LOAD or WRITE
- done  out  1  high in DONE
- word_count  out  CW  number of words written in the current load
- chk  out  32  XOR checksum; present only with the optional feature

Behaviour:
- Reset is asynchronous and active-high on reset; single clock clk.
- Reset values: state=IDLE, byte_ready=0, WE=0, A=BASE_ADDR, WD=0, busy=0, done=0, word_count=0, byte index=0, chk=0.
- A reset asserted mid-load aborts immediately and discards any partial word.
- IDLE:
  - start=1 -> LOAD; A=BASE_ADDR, word_count=0, byte index=0.
- LOAD:
  - byte_ready=1.
  - A byte transfers only on a cycle with byte_valid=1 and byte_ready=1.
  - Bytes assemble big-endian: the 1st byte goes to WD[31:24], the 4th to WD[7:0]. Byte index increments modulo 4.
  - On the 4th accepted byte, the assembled word is registered.
  - If that word equals 32'hFFFFFFFF, it is a terminator: no write occurs and the next state is DONE.
  - Otherwise the next state is WRITE.
- WRITE (exactly 1 cycle):
  - WE=1 with A and WD stable; byte_ready=0.
  - On exit: A+=4 (32-bit wrap), word_count+=1.
  - If the new word_count equals MAX_WORDS -> DONE, else -> LOAD.
- DONE:
  - done=1, byte_ready=0; A, WD and word_count hold their values.
  - start=1 -> LOAD with counters reinitialised as in IDLE.
- start is ignored while busy=1.
- byte_valid is ignored whenever byte_ready=0. The source must hold byte_data until the byte is accepted.
- Bytes offered while in DONE are not consumed (byte_ready=0).
- Latency: the 4th byte is accepted at edge N; WE is high in cycle N+1; byte_ready is high again in cycle N+2.
- Peak throughput: one word per 5 cycles.
- WE is never high outside WRITE and is never high for two consecutive cycles.
- MAX_WORDS boundary: the MAX_WORDS-th write ends the load even without a terminator. No write ever goes to address BASE_ADDR+4*MAX_WORDS or beyond.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - chk output exists.
  - In every WRITE cycle, chk <= chk ^ WD. Terminator words are not included.
  - chk clears on reset and on a start accepted from IDLE or DONE.
  - chk holds its value in DONE.
- Undefined:
  - chk port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: assert reset mid-byte, asynchronously between clock edges -> all outputs reach their reset values immediately; a fresh start then loads from BASE_ADDR.
- Basic load: start, then bytes 20 08 00 05, 20 09 00 0A, FF FF FF FF -> WE pulses with (A=0x00000000, WD=0x20080005), then (A=0x00000004, WD=0x2009000A); done=1, word_count=2, exactly 2 WE pulses.
- Handshake gaps: the same stream with byte_valid low on random cycles, plus bytes driven during WRITE -> identical writes; no byte is lost or duplicated; WE is always 1 cycle wide.
- Capacity: MAX_WORDS=4, 5 words sent with no terminator -> 4 writes to 0x0, 0x4, 0x8, 0xC; done=1, word_count=4; the 5th word's bytes see byte_ready=0.
- Restart: start pulsed while busy -> ignored. Then, from DONE, start and a new load with BASE_ADDR=32'h00001000 -> first write goes to A=0x00001000 and word_count restarts at 0.
- Checksum (macro defined): words 0x20080005 and 0x2009000A -> chk=0x0001000F in DONE; chk=0 after the next start.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader: packs big-endian bytes into 32-bit words
// and issues one-cycle writes. Optional XOR checksum output under IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64,
  parameter int          CW        = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          WE,
  output logic [31:0]   A,
  output logic [31:0]   WD,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]   chk
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [CW-1:0] LAST_COUNT = CW'(MAX_WORDS - 1);
  localparam logic [31:0]   TERMINATOR = 32'hFFFF_FFFF;

  state_t        r_state, w_next;
  logic [1:0]    r_idx;
  logic [31:0]   r_addr;
  logic [31:0]   r_wd;
  logic [CW-1:0] r_count;

  logic          w_accept;
  logic          w_start;
  logic [31:0]   w_word;

  assign w_accept = (r_state == S_LOAD) && byte_valid;
  assign w_start  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  // Bytes shift in from the bottom, so the first byte ends up in [31:24].
  assign w_word   = {r_wd[23:0], byte_data};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    WE         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid && (r_idx == 2'd3))
          w_next = (w_word == TERMINATOR) ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        WE     = 1'b1;
        busy   = 1'b1;
        w_next = (r_count == LAST_COUNT) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_addr  <= BASE_ADDR;
      r_wd    <= 32'h0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_addr  <= BASE_ADDR;
        r_count <= '0;
        r_idx   <= 2'd0;
      end else if (w_accept) begin
        r_wd  <= w_word;
        r_idx <= r_idx + 2'd1;
      end else if (r_state == S_WRITE) begin
        r_addr  <= r_addr + 32'd4;
        r_count <= r_count + CW'(1);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_chk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_chk <= 32'h0;
    else if (w_start)            r_chk <= 32'h0;
    else if (r_state == S_WRITE) r_chk <= r_chk ^ r_wd;
  end

  assign chk = r_chk;
`endif

  assign A          = r_addr;
  assign WD         = r_wd;
  assign word_count = r_count;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: three instances (default, MAX_WORDS=4,
// BASE_ADDR=0x1000) driven by directed and random loads against a word-level model.
module tb_imem_loader;

  localparam int          N = 3;
  localparam logic [31:0] BASES [N] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_1000};
  localparam int          MAXW  [N] = '{64, 4, 64};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [N];
  logic        st   [N];
  logic        bv   [N];
  logic [7:0]  bd   [N];
  logic        br   [N];
  logic        we   [N];
  logic        busy [N];
  logic        done [N];
  logic [31:0] a    [N];
  logic [31:0] wd   [N];
  logic [6:0]  wc   [N];
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] chk  [N];
`endif

  for (genvar g = 0; g < N; g++) begin : g_dut
    imem_loader #(.BASE_ADDR(BASES[g]), .MAX_WORDS(MAXW[g]), .CW(7)) u_dut (
      .clk        (clk),
      .reset      (rst[g]),
      .start      (st[g]),
      .byte_valid (bv[g]),
      .byte_data  (bd[g]),
      .byte_ready (br[g]),
      .WE         (we[g]),
      .A          (a[g]),
      .WD         (wd[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .word_count (wc[g])
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      .chk        (chk[g])
`endif
    );
  end

  int vectors     = 0;
  int miscompares = 0;

  // Write log filled by the monitor; each entry is {A, WD}.
  logic [63:0] wlog [N][0:255];
  int          wn   [N] = '{default: 0};
  bit          dbl  [N] = '{default: 1'b0};
  logic        pwe  [N] = '{default: 1'b0};

  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      if (we[d] === 1'b1) begin
        if (pwe[d] === 1'b1) dbl[d] = 1'b1;
        if (wn[d] < 256) wlog[d][wn[d]] = {a[d], wd[d]};
        wn[d]++;
      end
      pwe[d] = we[d];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input int d, input string tag);
    check({tag, "/byte_ready"}, 32'(br[d]), 32'd0);
    check({tag, "/WE"},         32'(we[d]), 32'd0);
    check({tag, "/A"},          a[d], BASES[d]);
    check({tag, "/WD"},         wd[d], 32'h0);
    check({tag, "/busy"},       32'(busy[d]), 32'd0);
    check({tag, "/done"},       32'(done[d]), 32'd0);
    check({tag, "/word_count"}, 32'(wc[d]), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check({tag, "/chk"},        chk[d], 32'h0);
`endif
  endtask

  // Offer one byte until accepted or max_wait cycles pass; random valid gaps when asked.
  task automatic send_byte(input int d, input logic [7:0] b, input bit gaps,
                           input int max_wait, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < max_wait && !ok; t++) begin
      @(negedge clk);
      bv[d] = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bd[d] = b;
      if (bv[d] && br[d] === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(negedge clk);
      bv[d] = 1'b0;
    end
  endtask

  task automatic pulse_start(input int d);
    @(negedge clk);
    bv[d] = 1'b0;
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
  endtask

  // One complete load: model predicts writes from the word list, then the stream is driven.
  task automatic run_load(input int d, input logic [31:0] words[$], input bit gaps,
                          input bit mid_start, input string tag);
    logic [63:0] exp_w[$];
    logic [31:0] xs, w;
    int          exp_acc, acc, mark;
    bit          ok;
    exp_w   = {};
    xs      = 32'h0;
    exp_acc = 0;
    foreach (words[i]) begin
      exp_acc += 4;
      if (words[i] == 32'hFFFF_FFFF) break;
      exp_w.push_back({BASES[d] + 32'(4 * exp_w.size()), words[i]});
      xs ^= words[i];
      if (exp_w.size() == MAXW[d]) break;
    end

    mark = wn[d];
    pulse_start(d);
    check({tag, "/wc_after_start"},   32'(wc[d]), 32'd0);
    check({tag, "/busy_after_start"}, 32'(busy[d]), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check({tag, "/chk_after_start"},  chk[d], 32'h0);
`endif
    acc = 0;
    foreach (words[i]) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        if (mid_start && acc == 5) begin
          @(negedge clk);
          bv[d] = 1'b0;
          check({tag, "/busy_at_ignored_start"}, 32'(busy[d]), 32'd1);
          st[d] = 1'b1;
          @(negedge clk);
          st[d] = 1'b0;
        end
        send_byte(d, w[31-8*k -: 8], gaps, (acc < exp_acc) ? 60 : 12, ok);
        if (ok) acc++;
      end
    end
    idle(d, 4);

    check({tag, "/bytes_accepted"}, 32'(acc), 32'(exp_acc));
    check({tag, "/write_count"},    32'(wn[d] - mark), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) begin
      check($sformatf("%s/A[%0d]", tag, i),  wlog[d][mark+i][63:32], exp_w[i][63:32]);
      check($sformatf("%s/WD[%0d]", tag, i), wlog[d][mark+i][31:0],  exp_w[i][31:0]);
    end
    check({tag, "/done"},       32'(done[d]), 32'd1);
    check({tag, "/busy"},       32'(busy[d]), 32'd0);
    check({tag, "/byte_ready"}, 32'(br[d]), 32'd0);
    check({tag, "/word_count"}, 32'(wc[d]), 32'(exp_w.size()));
    check({tag, "/we_single"},  32'(dbl[d]), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check({tag, "/chk"},        chk[d], xs);
`endif
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] r;
    bit          ok;

    for (int d = 0; d < N; d++) begin
      rst[d] = 1'b1;
      st[d]  = 1'b0;
      bv[d]  = 1'b0;
      bd[d]  = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < N; d++) check_reset(d, $sformatf("por%0d", d));
    for (int d = 0; d < N; d++) rst[d] = 1'b0;

    // Basic load; the model's XOR of the two words is 0x0001000F.
    q = {32'h2008_0005, 32'h2009_000A, 32'hFFFF_FFFF};
    run_load(0, q, 1'b0, 1'b0, "basic");

    // Same stream with random valid gaps and a start pulse that must be ignored.
    run_load(0, q, 1'b1, 1'b1, "gaps");

    // Asynchronous reset between edges in the middle of a word.
    pulse_start(0);
    send_byte(0, 8'hAB, 1'b0, 60, ok);
    send_byte(0, 8'hCD, 1'b0, 60, ok);
    @(negedge clk);
    bv[0] = 1'b0;
    #3 rst[0] = 1'b1;
    #1 check_reset(0, "async_rst");
    @(negedge clk);
    rst[0] = 1'b0;
    run_load(0, q, 1'b0, 1'b0, "after_rst");

    // Latency: 4th byte at edge N, WE in cycle N+1, byte_ready back in N+2.
    pulse_start(0);
    send_byte(0, 8'h12, 1'b0, 60, ok);
    send_byte(0, 8'h34, 1'b0, 60, ok);
    send_byte(0, 8'h56, 1'b0, 60, ok);
    send_byte(0, 8'h78, 1'b0, 60, ok);
    @(negedge clk);
    bv[0] = 1'b0;
    check("lat/WE_n1",  32'(we[0]), 32'd1);
    check("lat/A_n1",   a[0], BASES[0]);
    check("lat/WD_n1",  wd[0], 32'h1234_5678);
    check("lat/br_n1",  32'(br[0]), 32'd0);
    @(negedge clk);
    check("lat/WE_n2",  32'(we[0]), 32'd0);
    check("lat/br_n2",  32'(br[0]), 32'd1);
    check("lat/A_n2",   a[0], BASES[0] + 32'd4);
    for (int k = 0; k < 4; k++) send_byte(0, 8'hFF, 1'b0, 60, ok);
    idle(0, 3);
    check("lat/done", 32'(done[0]), 32'd1);
    check("lat/wc",   32'(wc[0]), 32'd1);

    // Random program on the default instance.
    q = {};
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      if (r == 32'hFFFF_FFFF) r = 32'h0;
      q.push_back(r);
    end
    q.push_back(32'hFFFF_FFFF);
    run_load(0, q, 1'b1, 1'b0, "random");

    // Capacity: MAX_WORDS=4, five words without terminator.
    q = {};
    for (int i = 0; i < 5; i++) begin
      r = $urandom;
      if (r == 32'hFFFF_FFFF) r = 32'h1;
      q.push_back(r);
    end
    run_load(1, q, 1'b0, 1'b0, "capacity");

    // Restart from DONE on the BASE_ADDR=0x1000 instance.
    q = {};
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      if (r == 32'hFFFF_FFFF) r = 32'h2;
      q.push_back(r);
    end
    q.push_back(32'hFFFF_FFFF);
    run_load(2, q, 1'b1, 1'b0, "base1000_first");
    q = {32'hCAFE_0001, 32'hFFFF_FFFF};
    run_load(2, q, 1'b0, 1'b0, "base1000_restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
